noc_fifo_ctrl: RTL and testbench

- Single-clock FIFO controller for the router input buffer; sits directly upstream of ram_8x32 and owns both of its ports.
- Turns a valid/ready push interface into RAM writes, and issues RAM reads to keep a 2-entry output stage filled (first-word-fall-through).
- Holds read data locally, because the RAM zeroes rd_data on any cycle rd_en is low.
- Total capacity is DEPTH + 2 flits.

---
 rtl/noc_fifo_ctrl_pkg.sv | 26 ++
 rtl/noc_fifo_ctrl_if.sv | 42 ++++
 rtl/noc_fifo_out_stage.sv | 51 +++++
 rtl/noc_fifo_ctrl.sv | 82 ++++++++
 tb/tb_noc_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_fifo_ctrl_pkg.sv
// Shared widths, sizes and helper types for the router input-buffer FIFO
// controller and its output stage. The optional almost-full threshold only
// exists when FIFO_AFULL_EN is defined.
package noc_fifo_ctrl_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int ADDR_WIDTH      = 3;
   localparam int RAM_SIZE        = 8;
   localparam int DEPTH           = RAM_SIZE;
   localparam int OUT_STAGE_DEPTH = 2;
   localparam int OCNT_W          = $clog2(OUT_STAGE_DEPTH + 1);
`ifdef FIFO_AFULL_EN
   localparam int AFULL_TH        = 6;
`endif

   typedef logic [DATA_WIDTH-1:0] flit_t;
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef logic [ADDR_WIDTH:0]   cnt_t;
   typedef logic [OCNT_W-1:0]     ocnt_t;

   // Pointers wrap 7 -> 0 by natural overflow because DEPTH == 2**ADDR_WIDTH.
   function automatic addr_t ptr_inc(input addr_t p);
      return p + addr_t'(1);
   endfunction

endpackage

// File: rtl/noc_fifo_ctrl_if.sv
// Bus bundle for noc_fifo_ctrl: push side, pop side and both RAM ports.
// The slave modport is the controller; master is its environment.
// almost_full exists only when FIFO_AFULL_EN is defined.
interface noc_fifo_ctrl_if;
   import noc_fifo_ctrl_pkg::*;

   logic  in_valid;
   logic  in_ready;
   flit_t in_data;
   logic  out_valid;
   logic  out_ready;
   flit_t out_data;
   logic  ram_rst_n;
   logic  ram_wr_en;
   addr_t ram_wr_addr;
   flit_t ram_wr_data;
   logic  ram_rd_en;
   addr_t ram_rd_addr;
   flit_t ram_rd_data;
`ifdef FIFO_AFULL_EN
   logic  almost_full;
`endif

   modport slave (
      input  in_valid, in_data, out_ready, ram_rd_data,
      output in_ready, out_valid, out_data, ram_rst_n,
      output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_AFULL_EN
      , output almost_full
`endif
   );

   modport master (
      output in_valid, in_data, out_ready, ram_rd_data,
      input  in_ready, out_valid, out_data, ram_rst_n,
      input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr
`ifdef FIFO_AFULL_EN
      , input almost_full
`endif
   );

endinterface

// File: rtl/noc_fifo_out_stage.sv
// Two-entry first-word-fall-through output stage (head + skid). Captures
// RAM read data one cycle after a read issue and serves the pop handshake.
// occ_after_pop_o lets the parent reserve a slot for every read in flight.
module noc_fifo_out_stage
   import noc_fifo_ctrl_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  rd_pend_i,
   input  flit_t rd_data_i,
   input  logic  out_ready_i,
   output logic  out_valid_o,
   output flit_t out_data_o,
   output ocnt_t occ_after_pop_o
);

   flit_t head_q;
   flit_t skid_q;
   ocnt_t cnt_q;
   ocnt_t cnt_d;
   logic  pop;

   assign out_valid_o     = (cnt_q != '0);
   assign out_data_o      = head_q;
   assign pop             = out_valid_o && out_ready_i;
   assign occ_after_pop_o = cnt_q - ocnt_t'(pop);
   assign cnt_d           = occ_after_pop_o + ocnt_t'(rd_pend_i);

   // Shift skid to head on pop, then drop returning RAM data into the first
   // slot that is free once this cycle's pop is accounted for.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q <= '0;
         skid_q <= '0;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         // Head only moves when a second entry exists, so out_data holds
         // the last flit while the stage is empty.
         if (pop && (cnt_q == ocnt_t'(OUT_STAGE_DEPTH)))
            head_q <= skid_q;
         if (rd_pend_i) begin
            if (occ_after_pop_o == '0)
               head_q <= rd_data_i;
            else
               skid_q <= rd_data_i;
         end
      end
   end

endmodule

// File: rtl/noc_fifo_ctrl.sv
// Router input-buffer FIFO controller in front of ram_8x32. Writes pushes
// straight into the RAM and issues reads to keep a 2-entry output stage full.
// Total capacity is DEPTH + 2 flits. Define FIFO_AFULL_EN to add a registered
// almost_full flag on RAM occupancy.
module noc_fifo_ctrl
   import noc_fifo_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   noc_fifo_ctrl_if.slave fifo_if
);

   addr_t           wr_ptr_q;
   addr_t           rd_ptr_q;
   cnt_t            ram_cnt_q;
   cnt_t            ram_cnt_d;
   logic            rd_pend_q;
   logic            wr_fire;
   logic            rd_issue;
   ocnt_t           occ_after_pop;
   logic [OCNT_W:0] stage_use;

   assign fifo_if.ram_rst_n = ~rst;
   assign fifo_if.in_ready  = (ram_cnt_q != cnt_t'(DEPTH));
   assign wr_fire           = fifo_if.in_valid && fifo_if.in_ready;

   // Slots already taken after this cycle's pop, plus the read still in flight.
   assign stage_use = {1'b0, occ_after_pop} + {{OCNT_W{1'b0}}, rd_pend_q};
   // A just-written entry is not counted yet, so rd/wr never hit one address.
   assign rd_issue  = (ram_cnt_q != '0) &&
                      (stage_use < (OCNT_W+1)'(OUT_STAGE_DEPTH));
   assign ram_cnt_d = ram_cnt_q + cnt_t'(wr_fire) - cnt_t'(rd_issue);

   assign fifo_if.ram_wr_en   = wr_fire;
   assign fifo_if.ram_wr_addr = wr_ptr_q;
   assign fifo_if.ram_wr_data = fifo_if.in_data;
   assign fifo_if.ram_rd_en   = rd_issue;
   assign fifo_if.ram_rd_addr = rd_ptr_q;

   // Pointer, occupancy and read-in-flight bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ram_cnt_q <= '0;
         rd_pend_q <= 1'b0;
      end else begin
         if (wr_fire)
            wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (rd_issue)
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         ram_cnt_q <= ram_cnt_d;
         rd_pend_q <= rd_issue;
      end
   end

`ifdef FIFO_AFULL_EN
   logic almost_full_q;

   // Lookahead flag for NoC credits: tracks next-cycle RAM occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         almost_full_q <= 1'b0;
      else
         almost_full_q <= (ram_cnt_d >= cnt_t'(AFULL_TH));
   end

   assign fifo_if.almost_full = almost_full_q;
`endif

   noc_fifo_out_stage u_out_stage (
      .clk             (clk),
      .rst             (rst),
      .rd_pend_i       (rd_pend_q),
      .rd_data_i       (fifo_if.ram_rd_data),
      .out_ready_i     (fifo_if.out_ready),
      .out_valid_o     (fifo_if.out_valid),
      .out_data_o      (fifo_if.out_data),
      .occ_after_pop_o (occ_after_pop)
   );

endmodule

// File: tb/tb_noc_fifo_ctrl.sv
// Directed bench for noc_fifo_ctrl with a behavioural ram_8x32 model
// (registered read, rd_data forced to zero when rd_en is low).
// Almost-full checks are compiled in when FIFO_AFULL_EN is defined.
module tb_noc_fifo_ctrl;
   import noc_fifo_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   noc_fifo_ctrl_if bus();

   noc_fifo_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .fifo_if (bus)
   );

   // ram_8x32 model
   flit_t mem [DEPTH];
   always @(posedge clk or negedge bus.ram_rst_n) begin
      if (!bus.ram_rst_n) begin
         bus.ram_rd_data <= '0;
      end else begin
         if (bus.ram_wr_en)
            mem[bus.ram_wr_addr] <= bus.ram_wr_data;
         bus.ram_rd_data <= bus.ram_rd_en ? mem[bus.ram_rd_addr] : '0;
      end
   end

   typedef struct {
      logic  iv;
      flit_t d;
      logic  ordy;
      logic  e_ir;
      logic  e_ov;
      flit_t e_od;
      logic  e_we;
      logic  e_re;
   } vec_t;

   vec_t  vt [10];
   int    n_checks = 0;
   int    n_fail   = 0;
   flit_t sb_q [$];
   int    tb_out_cnt = 0;
   int    tb_pend    = 0;
   int    pops       = 0;
   int    cyc        = 0;
   int    first_pop  = -1;
   int    last_pop   = -1;
   flit_t last_pop_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic iv, input flit_t d, input logic ordy);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
   endtask

   // Scoreboard and output-stage slot accounting, evaluated before the edge.
   task automatic observe();
      logic pop;
      pop = bus.out_valid && bus.out_ready;
      check("out_valid_vs_slots", bus.out_valid, (tb_out_cnt != 0));
      if (pop) begin
         if (sb_q.size() == 0) begin
            check("pop_from_empty", 1, 0);
         end else begin
            last_pop_data = sb_q.pop_front();
            check("pop_data", bus.out_data, last_pop_data);
         end
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
      end
      if (bus.in_valid && bus.in_ready)
         sb_q.push_back(bus.in_data);
      if (bus.ram_rd_en)
         check("rd_slot_reserved", ((tb_out_cnt - int'(pop) + tb_pend) < 2), 1);
      tb_out_cnt = tb_out_cnt - int'(pop) + tb_pend;
      tb_pend    = int'(bus.ram_rd_en);
   endtask

   task automatic tick();
      observe();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_stats();
      pops = 0; first_pop = -1; last_pop = -1;
   endtask

   initial begin
      int sent;
      int acc;
      drive(1'b0, '0, 1'b0);

      // Per-cycle vectors from reset: {in_valid, in_data, out_ready |
      // in_ready, out_valid, out_data, ram_wr_en, ram_rd_en}
      vt[0] = '{1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0};
      vt[1] = '{1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1};
      vt[2] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1};
      vt[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b0};
      vt[4] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0, 1'b0};
      vt[5] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h22, 1'b1, 1'b0};
      vt[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 1'b1};
      vt[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0};
      vt[8] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h33, 1'b0, 1'b0};
      vt[9] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h33, 1'b0, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data",  bus.out_data,  0);
      check("rst_ram_wr_en", bus.ram_wr_en, 0);
      check("rst_ram_rd_en", bus.ram_rd_en, 0);
      @(posedge clk);
      #1;

      // Table-driven latency and hold behaviour
      for (int i = 0; i < 10; i++) begin
         drive(vt[i].iv, vt[i].d, vt[i].ordy);
         @(negedge clk);
         check($sformatf("vec%0d_in_ready", i),  bus.in_ready,  vt[i].e_ir);
         check($sformatf("vec%0d_out_valid", i), bus.out_valid, vt[i].e_ov);
         check($sformatf("vec%0d_out_data", i),  bus.out_data,  vt[i].e_od);
         check($sformatf("vec%0d_ram_wr_en", i), bus.ram_wr_en, vt[i].e_we);
         check($sformatf("vec%0d_ram_rd_en", i), bus.ram_rd_en, vt[i].e_re);
         tick();
      end

      // Steady state: push and pop every cycle
      clear_stats();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, flit_t'($urandom), 1'b1);
         @(negedge clk);
         check("steady_in_ready", bus.in_ready, 1);
         if (i >= 1) check("steady_cnt_const", bus.ram_rd_en, bus.ram_wr_en);
         tick();
      end
      for (int i = 0; i < 10 && pops < 20; i++) begin
         drive(1'b0, '0, 1'b1);
         @(negedge clk);
         tick();
      end
      check("steady_pops", pops, 20);
      check("steady_span", last_pop - first_pop, 19);
      repeat (3) begin drive(1'b0, '0, 1'b0); @(negedge clk); tick(); end

      // Fill to capacity with output blocked; 11th push must be refused
      acc = 0;
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, (i < 10) ? flit_t'(i) : 32'hB, 1'b0);
         @(negedge clk);
         if (i < 10) begin
            check("fill_in_ready", bus.in_ready, 1);
         end else begin
            check("full_in_ready", bus.in_ready, 0);
            check("full_wr_en",    bus.ram_wr_en, 0);
         end
`ifdef FIFO_AFULL_EN
         check("fill_almost_full", bus.almost_full, (i >= 8));
`endif
         if (bus.in_valid && bus.in_ready) acc++;
         tick();
      end
      check("fill_accepted", acc, 10);

      // Drain: 0..9 in order, one per cycle, then empty
      clear_stats();
      for (int j = 0; j < 12; j++) begin
         drive(1'b0, '0, 1'b1);
         @(negedge clk);
         check("drain_out_valid", bus.out_valid, (j < 10));
`ifdef FIFO_AFULL_EN
         check("drain_almost_full", bus.almost_full, (j < 3));
`endif
         tick();
      end
      check("drain_pops", pops, 10);
      check("drain_span", last_pop - first_pop, 9);
      check("drain_sb_empty", sb_q.size(), 0);

      // Random backpressure, 100 flits
      clear_stats();
      sent = 0;
      for (int k = 0; k < 3000 && pops < 100; k++) begin
         drive(sent < 100, flit_t'($urandom), 1'($urandom_range(0, 1)));
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) sent++;
         tick();
      end
      check("bp_pops", pops, 100);
      check("bp_sb_empty", sb_q.size(), 0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, flit_t'(32'h100 + i), 1'b0);
         @(negedge clk);
         tick();
      end
      drive(1'b0, '0, 1'b0);
      rst = 1'b1;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_in_ready",  bus.in_ready,  1);
      check("midrst_ram_wr_en", bus.ram_wr_en, 0);
      check("midrst_out_data",  bus.out_data,  0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb_q.delete();
      tb_out_cnt = 0;
      tb_pend    = 0;
      clear_stats();
      drive(1'b1, 32'hA5, 1'b1);
      @(negedge clk);
      tick();
      for (int i = 0; i < 10 && pops < 1; i++) begin
         drive(1'b0, '0, 1'b1);
         @(negedge clk);
         tick();
      end
      check("midrst_pops", pops, 1);
      check("midrst_first_flit", last_pop_data, 32'hA5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
